spi_slave_sync: RTL and testbench

//  Parametrised SPI slave for the board's command path. sclk/cs/mosi are oversampled into the

---
 rtl/spi_slave_sync.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave with sclk/cs/mosi oversampled into the system clock domain.
// Optional MISO transmit path is built only when SPI_SLAVE_TX_EN is defined.
module spi_slave_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_first,
  output logic             rx_abort,
  output logic             frame_end,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack
);

  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam logic        IdleLvl = (CPOL != 0);

  typedef enum logic [0:0] {StIdle, StActive} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q, armed_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  logic                   active, start, stop, do_sample, do_shift;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic                   first_q, word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | cs_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = (sclk_prev_q == IdleLvl) && (sclk_s != IdleLvl);
  assign trail_edge  = (sclk_prev_q != IdleLvl) && (sclk_s == IdleLvl);
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall && armed_q) state_d = StActive;
      StActive: if (cs_rise)            state_d = StIdle;
      default:                          state_d = StIdle;
    endcase
  end

  // Sampling stays enabled in the cs-rise cycle so a completing word is not lost.
  always_comb begin
    active    = (state_q == StActive);
    start     = (state_q == StIdle) && cs_fall && armed_q;
    stop      = active && cs_rise;
    do_sample = active && sample_edge;
    do_shift  = active && shift_edge;
  end

  always_comb begin
    rx_shift_d = rx_shift_q;
    cnt_d      = cnt_q;
    word_done  = 1'b0;
    if (do_sample) begin
      if (MSB_FIRST != 0) rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
      else                rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
      if (cnt_q == CntW'(WIDTH - 1)) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rx_shift_q <= '0;
      first_q    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      rx_abort   <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      rx_abort   <= 1'b0;
      frame_end  <= 1'b0;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      if (word_done) begin
        rx_data  <= rx_shift_d;
        rx_valid <= 1'b1;
        rx_first <= first_q;
        first_q  <= 1'b0;
      end
      if (start) begin
        cnt_q      <= '0;
        rx_shift_q <= '0;
        first_q    <= 1'b1;
      end
      if (stop) begin
        frame_end  <= 1'b1;
        rx_abort   <= (cnt_d != '0);
        cnt_q      <= '0;
        rx_shift_q <= '0;
      end
    end
  end

`ifdef SPI_SLAVE_TX_EN
  logic [WIDTH-1:0] tx_shift_q;
  logic             wrap_q, skip_q;

  // skip_q holds the preloaded first bit across the first leading edge when CPHA=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '0;
      tx_ack     <= 1'b0;
      wrap_q     <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      tx_ack <= 1'b0;
      if (start) begin
        tx_shift_q <= tx_data;
        tx_ack     <= 1'b1;
        wrap_q     <= 1'b0;
        skip_q     <= (CPHA != 0);
      end else if (do_shift) begin
        if (wrap_q) begin
          tx_shift_q <= tx_data;
          tx_ack     <= 1'b1;
          wrap_q     <= 1'b0;
        end else if (skip_q) begin
          skip_q <= 1'b0;
        end else if (MSB_FIRST != 0) begin
          tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
        end else begin
          tx_shift_q <= {1'b0, tx_shift_q[WIDTH-1:1]};
        end
      end
      if (word_done) wrap_q <= 1'b1;
    end
  end

  assign miso = active && ((MSB_FIRST != 0) ? tx_shift_q[WIDTH-1] : tx_shift_q[0]);
`else
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign miso      = 1'b0;
  assign tx_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: three DUT configurations, directed and random frames.
module tb_spi_slave_sync;

  localparam int unsigned NB = 3;
  localparam int unsigned WID  [NB] = '{8, 16, 8};
  localparam int unsigned CPOLP[NB] = '{0, 1, 0};
  localparam int unsigned CPHAP[NB] = '{0, 1, 1};
  localparam int unsigned MSBP [NB] = '{1, 1, 0};
  localparam int HALF = 50;

  typedef struct packed {
    logic [1:0]  bus;
    logic        valid;
    logic        first;
    logic        abort;
    logic        fend;
    logic [31:0] data;
  } ev_t;

  ev_t         expq[$];
  int          total = 0;
  int          bad = 0;
  int          ev_seen = 0;
  int          ack_total[NB] = '{default: 0};
  int          ack_base[NB] = '{default: 0};
  logic [31:0] last_data[NB] = '{default: 0};
  logic [31:0] txw[8] = '{default: 0};
  logic [31:0] fw[4] = '{default: 0};
  logic [31:0] tdw[NB] = '{default: 0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] sclk, csn, mosi, miso, rv, rf, ra, fe, tack;
  logic [7:0]    rd0, rd2;
  logic [15:0]   rd1;

  always #5 clk = ~clk;

  spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .cs(csn[0]), .mosi(mosi[0]), .miso(miso[0]),
    .rx_data(rd0), .rx_valid(rv[0]), .rx_first(rf[0]), .rx_abort(ra[0]), .frame_end(fe[0]),
    .tx_data(tdw[0][7:0]), .tx_ack(tack[0])
  );

  spi_slave_sync #(.WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .cs(csn[1]), .mosi(mosi[1]), .miso(miso[1]),
    .rx_data(rd1), .rx_valid(rv[1]), .rx_first(rf[1]), .rx_abort(ra[1]), .frame_end(fe[1]),
    .tx_data(tdw[1][15:0]), .tx_ack(tack[1])
  );

  spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[2]), .cs(csn[2]), .mosi(mosi[2]), .miso(miso[2]),
    .rx_data(rd2), .rx_valid(rv[2]), .rx_first(rf[2]), .rx_abort(ra[2]), .frame_end(fe[2]),
    .tx_data(tdw[2][7:0]), .tx_ack(tack[2])
  );

  function automatic logic [31:0] rd_of(input int b);
    case (b)
      0:       return 32'(rd0);
      1:       return 32'(rd1);
      default: return 32'(rd2);
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int b);
    return (WID[b] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << WID[b]) - 32'h1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  // Monitor: tracks tx_ack, presents the next tx word, and scores every rx-side event.
  ev_t         mon_e;
  logic [63:0] mon_act;
  always @(negedge clk) begin
    for (int b = 0; b < int'(NB); b++) begin
      int idx;
      if (rst_n && tack[b]) ack_total[b]++;
      idx = ack_total[b] - ack_base[b];
      if (idx > 7) idx = 7;
      if (idx < 0) idx = 0;
      tdw[b] = txw[idx];
      if (rst_n && (rv[b] || ra[b] || fe[b])) begin
        ev_seen++;
        mon_act = 64'({2'(b), rv[b], rf[b], ra[b], fe[b], rd_of(b)});
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %0h, required no event", mon_act);
        end else begin
          mon_e = expq.pop_front();
          check("rx_event", mon_act, 64'(mon_e));
        end
      end
    end
  end

  task automatic send_bits(input int b, input logic [31:0] word, input int nbits,
                           output logic [31:0] cap);
    int   idx;
    logic idle;
    idle = (CPOLP[b] != 0);
    cap  = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = (MSBP[b] != 0) ? int'(WID[b]) - 1 - i : i;
      if (CPHAP[b] == 0) begin
        mosi[b] = word[idx];
        #HALF;
        cap[idx] = miso[b];
        sclk[b]  = ~idle;
        #HALF;
        sclk[b]  = idle;
      end else begin
        sclk[b] = ~idle;
        mosi[b] = word[idx];
        #HALF;
        cap[idx] = miso[b];
        sclk[b]  = idle;
        #HALF;
      end
    end
  endtask

  // Frame of nwords full words from fw[], then `partial` bits of fw[nwords]; tx words from txw[].
  task automatic run_frame(input int b, input int nwords, input int partial);
    logic [31:0] cap, m;
    int          nbits, exp_ack;
    ev_t         e;
    m           = mask_of(b);
    ack_base[b] = ack_total[b];
    @(negedge clk);
    csn[b] = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < nwords; k++) begin
      e.bus = 2'(b); e.valid = 1'b1; e.first = (k == 0); e.abort = 1'b0; e.fend = 1'b0;
      e.data = fw[k] & m;
      expq.push_back(e);
      last_data[b] = fw[k] & m;
      send_bits(b, fw[k], int'(WID[b]), cap);
`ifdef SPI_SLAVE_TX_EN
      check("miso_word", 64'(cap & m), 64'(txw[k] & m));
`endif
    end
    if (partial > 0) send_bits(b, fw[nwords], partial, cap);
    repeat (6) @(negedge clk);
    e.bus = 2'(b); e.valid = 1'b0; e.first = 1'b0; e.abort = (partial > 0); e.fend = 1'b1;
    e.data = last_data[b];
    expq.push_back(e);
    csn[b] = 1'b1;
    repeat (8) @(negedge clk);
    check("miso_idle", 64'(miso[b]), 64'd0);
    nbits = nwords * int'(WID[b]) + partial;
`ifdef SPI_SLAVE_TX_EN
    if (CPHAP[b] == 0) exp_ack = 1 + nwords;
    else               exp_ack = 1 + ((nbits > 0) ? (nbits - 1) / int'(WID[b]) : 0);
`else
    exp_ack = 0;
`endif
    check("tx_ack_count", 64'(ack_total[b] - ack_base[b]), 64'(exp_ack));
    check("events_drained", 64'(expq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int b = 0; b < int'(NB); b++) begin
      check({tag, "_flags"}, 64'({rv[b], rf[b], ra[b], fe[b], tack[b], miso[b]}), 64'd0);
      check({tag, "_rx_data"}, 64'(rd_of(b)), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] cap;
    int          base_ev;
    for (int b = 0; b < int'(NB); b++) sclk[b] = (CPOLP[b] != 0);
    csn  = '1;
    mosi = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Two back-to-back words, then a 5-bit abort that must keep rx_data.
    fw[0] = 32'hA5; fw[1] = 32'hB3;
    for (int k = 0; k < 8; k++) txw[k] = $urandom;
    run_frame(0, 2, 0);
    fw[0] = 32'hC3;
    run_frame(0, 0, 5);

    fw[0] = 32'hBEEF;
    run_frame(1, 1, 0);

    // LSB-first: wire order 1,0,1,0,0,1,0,1.
    fw[0] = 32'hA5;
    run_frame(2, 1, 0);

    txw[0] = 32'h3C; txw[1] = 32'h81;
    fw[0] = $urandom; fw[1] = $urandom;
    run_frame(2, 2, 0);

    run_frame(0, 0, 0);

    // Reset mid-frame with cs held low: that frame must be ignored entirely.
    @(negedge clk);
    csn[0] = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(0, 32'h96, 4, cap);
    base_ev = ev_seen;
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < int'(NB); b++) last_data[b] = '0;
    send_bits(0, 32'h96, 4, cap);
    send_bits(0, 32'h3E, 8, cap);
    repeat (6) @(negedge clk);
    csn[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("no_events_after_reset", 64'(ev_seen - base_ev), 64'd0);
    check("rx_data_after_reset", 64'(rd_of(0)), 64'd0);
    fw[0] = 32'h5A;
    run_frame(0, 1, 0);

    for (int r = 0; r < 24; r++) begin
      int b, nw, pb;
      b  = int'($urandom_range(0, NB - 1));
      nw = int'($urandom_range(0, 3));
      pb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, WID[b] - 1)) : 0;
      for (int k = 0; k < 4; k++) fw[k] = $urandom;
      for (int k = 0; k < 8; k++) txw[k] = $urandom;
      run_frame(b, nw, pb);
    end

    for (int i = 0; i < 500 && expq.size() != 0; i++) @(negedge clk);
    check("final_drain", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
